multi_string_matcher: RTL and testbench

//  Parametrised multi-pattern byte-string matcher for the Ethernet sniffer datapath.

---
 rtl/multi_string_matcher.sv | 135 +++++++++++++
 tb/tb_multi_string_matcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_string_matcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_string_matcher: multi-pattern byte-string matcher, 1-cycle pass-through
// Rev 1.0
// ----------------------------------------------------------------------------
module multi_string_matcher #(
  parameter int NUM_PATTERNS = 4,
  parameter int MAX_LEN      = 16,
  parameter int BPW          = 4,
  localparam int SW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    prog_we,
  input  logic                    prog_len_we,
  input  logic [SW-1:0]           prog_sel,
  input  logic [AW-1:0]           prog_addr,
  input  logic [7:0]              prog_char,
  input  logic [LW-1:0]           prog_len,
  input  logic                    data_valid,
  input  logic [8*BPW-1:0]        data_in,
  output logic [8*BPW-1:0]        data_out,
  output logic                    data_out_valid,
  output logic                    match,
  output logic [NUM_PATTERNS-1:0] match_vec,
  output logic [SW-1:0]           match_idx,
  output logic [NUM_PATTERNS-1:0] match_sticky
);

  localparam int W  = MAX_LEN + BPW - 1;
  localparam int CW = $clog2(W + 1);

  // Window index 0 holds the newest byte; higher indices are older.
  logic [7:0]              win      [W];
  logic [7:0]              win_next [W];
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic [7:0]              pat      [NUM_PATTERNS][MAX_LEN];
  logic [LW-1:0]           len      [NUM_PATTERNS];
  logic [NUM_PATTERNS-1:0] hit;
  logic [SW-1:0]           hit_idx;
  logic                    ok;

  always_comb begin
    for (int i = 0; i < BPW; i++) begin
      win_next[i] = data_in[8*i +: 8];
    end
    for (int i = BPW; i < W; i++) begin
      win_next[i] = win[i-BPW];
    end

    if (int'(cnt) + BPW >= W) cnt_next = CW'(W);
    else                      cnt_next = cnt + CW'(BPW);

    // Compare each pattern backwards from its last byte, which sits at byte k
    // of the new word; positions beyond the bytes seen so far never match.
    ok  = 1'b0;
    hit = '0;
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      for (int k = 0; k < BPW; k++) begin
        ok = (len[p] != '0);
        for (int d = 0; d < MAX_LEN; d++) begin
          if (d < int'(len[p])) begin
            if ((BPW - 1 - k + d) >= int'(cnt_next)) begin
              ok = 1'b0;
            end else if (win_next[BPW-1-k+d] != pat[p][AW'(int'(len[p]) - 1 - d)]) begin
              ok = 1'b0;
            end
          end
        end
        hit[p] = hit[p] | ok;
      end
    end

    hit_idx = '0;
    for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
      if (hit[p]) hit_idx = SW'(p);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < W; i++) win[i] <= '0;
      cnt            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      match          <= 1'b0;
      match_vec      <= '0;
      match_idx      <= '0;
      match_sticky   <= '0;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        len[p] <= '0;
        for (int a = 0; a < MAX_LEN; a++) pat[p][a] <= '0;
      end
    end else begin
      if (clear) begin
        for (int i = 0; i < W; i++) win[i] <= '0;
        cnt            <= '0;
        data_out       <= '0;
        data_out_valid <= 1'b0;
        match          <= 1'b0;
        match_vec      <= '0;
        match_idx      <= '0;
        match_sticky   <= '0;
      end else if (data_valid) begin
        for (int i = 0; i < W; i++) win[i] <= win_next[i];
        cnt            <= cnt_next;
        data_out       <= data_in;
        data_out_valid <= 1'b1;
        match          <= |hit;
        match_vec      <= hit;
        match_idx      <= hit_idx;
        match_sticky   <= match_sticky | hit;
      end else begin
        data_out_valid <= 1'b0;
        match          <= 1'b0;
        match_vec      <= '0;
        match_idx      <= '0;
      end

      // Pattern programming is independent of clear and of the stream.
      if (prog_we && int'(prog_sel) < NUM_PATTERNS && int'(prog_addr) < MAX_LEN) begin
        pat[prog_sel][prog_addr] <= prog_char;
      end
      if (prog_len_we && int'(prog_sel) < NUM_PATTERNS) begin
        len[prog_sel] <= (prog_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : prog_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_string_matcher.sv
`default_nettype none
// Scoreboard bench for multi_string_matcher: stream-history reference model,
// directed scenarios followed by a randomized phase.
module tb_multi_string_matcher;
  localparam int NP  = 4;
  localparam int ML  = 16;
  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear = 1'b0;
  logic        prog_we = 1'b0;
  logic        prog_len_we = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_char = '0;
  logic [4:0]  prog_len = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        match;
  logic [3:0]  match_vec;
  logic [1:0]  match_idx;
  logic [3:0]  match_sticky;

  multi_string_matcher #(.NUM_PATTERNS(NP), .MAX_LEN(ML), .BPW(BPW)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .prog_we(prog_we), .prog_len_we(prog_len_we),
    .prog_sel(prog_sel), .prog_addr(prog_addr), .prog_char(prog_char), .prog_len(prog_len),
    .data_valid(data_valid), .data_in(data_in), .data_out(data_out),
    .data_out_valid(data_out_valid), .match(match), .match_vec(match_vec),
    .match_idx(match_idx), .match_sticky(match_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  vec;
    logic [1:0]  idx;
    logic [3:0]  sticky;
  } exp_t;

  exp_t         sb[$];
  int           compared = 0;
  int           mismatched = 0;
  byte unsigned m_pat[NP][ML];
  int           m_len[NP];
  byte unsigned hist[$];
  logic [3:0]   m_sticky;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int p = NP - 1; p >= 0; p--) if (v[p]) r = 2'(p);
    return r;
  endfunction

  // Append the word to the stream history and report which patterns end in it.
  function automatic logic [3:0] model_word(input logic [31:0] w);
    logic [3:0] v = '0;
    int base = hist.size();
    for (int k = 0; k < BPW; k++) hist.push_back(w[8*(BPW-1-k) +: 8]);
    for (int p = 0; p < NP; p++) begin
      int L = m_len[p];
      if (L == 0) continue;
      for (int k = 0; k < BPW; k++) begin
        int e = base + k;
        bit good = 1'b1;
        if (e + 1 < L) continue;
        for (int j = 0; j < L; j++) if (hist[e-L+1+j] != m_pat[p][j]) good = 1'b0;
        if (good) v[p] = 1'b1;
      end
    end
    while (hist.size() > 64) void'(hist.pop_front());
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_len[p] = 0;
      for (int j = 0; j < ML; j++) m_pat[p][j] = 8'h00;
    end
    hist.delete();
    m_sticky = '0;
  endtask

  // Expectations use the model state before this edge's programming lands.
  task automatic tick();
    exp_t e;
    if (clear) begin
      hist.delete();
      m_sticky = '0;
    end else if (data_valid) begin
      e.vec    = model_word(data_in);
      m_sticky = m_sticky | e.vec;
      e.data   = data_in;
      e.idx    = lowest(e.vec);
      e.sticky = m_sticky;
      sb.push_back(e);
    end
    if (prog_we) m_pat[prog_sel][prog_addr] = prog_char;
    if (prog_len_we) m_len[prog_sel] = (int'(prog_len) > ML) ? ML : int'(prog_len);
    @(posedge clk); #1;
    data_valid = 1'b0; clear = 1'b0; prog_we = 1'b0; prog_len_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    data_valid = 1'b1; data_in = w; tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
  endtask

  task automatic prog_byte(input int sel, input int addr, input logic [7:0] ch);
    prog_we = 1'b1; prog_sel = 2'(sel); prog_addr = 4'(addr); prog_char = ch; tick();
  endtask

  task automatic prog_length(input int sel, input int l);
    prog_len_we = 1'b1; prog_sel = 2'(sel); prog_len = 5'(l); tick();
  endtask

  task automatic prog_str(input int sel, input string s);
    for (int i = 0; i < s.len(); i++) prog_byte(sel, i, s[i]);
    prog_length(sel, s.len());
  endtask

  function automatic logic [7:0] alpha();
    return ($urandom_range(9) == 0) ? 8'h43 : 8'(8'h41 + $urandom_range(1));
  endfunction

  // Monitor: pops one expectation per presented output word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(data_out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          chk("match_vec", 32'(match_vec), 32'(e.vec));
          chk("match", 32'(match), 32'(|e.vec));
          chk("match_idx", 32'(match_idx), 32'(e.idx));
          chk("match_sticky", 32'(match_sticky), 32'(e.sticky));
        end
      end else begin
        chk("idle_match_vec", 32'(match_vec), 32'd0);
        chk("idle_match", 32'(match), 32'd0);
      end
    end
  end

  initial begin
    int wait_cycles;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_valid", 32'(data_out_valid), 32'd0);
    chk("reset_sticky", 32'(match_sticky), 32'd0);
    chk("reset_idx", 32'(match_idx), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // EVIL straddling two words
    prog_str(0, "EVIL");
    send(32'h41455649);
    chk("t1_first_match", 32'(match), 32'd0);
    send(32'h4C424344);
    chk("t1_vec", 32'(match_vec), 32'h1);
    chk("t1_idx", 32'(match_idx), 32'd0);
    chk("t1_data", data_out, 32'h4C424344);

    // two slots hitting in one word
    prog_str(1, "AB");
    prog_str(3, "B");
    do_clear();
    send(32'h00414200);
    chk("t2_vec", 32'(match_vec), 32'hA);
    chk("t2_idx", 32'(match_idx), 32'd1);
    idle(2);
    chk("t2_sticky", 32'(match_sticky), 32'hA);

    // five zero bytes need two words of history
    for (int i = 0; i < 5; i++) prog_byte(2, i, 8'h00);
    prog_length(2, 5);
    do_clear();
    send(32'h0);
    chk("t3_vec_w1", 32'(match_vec), 32'h0);
    send(32'h0);
    chk("t3_vec_w2", 32'(match_vec), 32'h4);

    // full-length pattern
    for (int i = 0; i < ML; i++) prog_byte(0, i, 8'h5A);
    prog_length(0, ML);
    do_clear();
    for (int i = 0; i < 3; i++) send(32'h5A5A5A5A);
    chk("t4_vec_w3", 32'(match_vec), 32'h0);
    send(32'h5A5A5A5A);
    chk("t4_vec_w4", 32'(match_vec), 32'h1);
    send(32'h5A5A5A5A);
    chk("t4_vec_w5", 32'(match_vec), 32'h1);

    // clear with a simultaneous word drops it
    do_clear();
    send(32'h5A5A5A5A);
    send(32'h5A5A5A5A);
    clear = 1'b1; data_valid = 1'b1; data_in = 32'h5A5A5A5A; tick();
    chk("t5_valid", 32'(data_out_valid), 32'd0);
    chk("t5_sticky", 32'(match_sticky), 32'd0);
    chk("t5_data", data_out, 32'd0);
    for (int i = 0; i < 3; i++) send(32'h5A5A5A5A);
    chk("t5_vec_w3", 32'(match_vec), 32'h0);
    send(32'h5A5A5A5A);
    chk("t5_vec_w4", 32'(match_vec), 32'h1);

    // randomized phase
    do_clear();
    for (int p = 0; p < NP; p++) begin
      int L = $urandom_range(1, 4);
      for (int j = 0; j < L; j++) prog_byte(p, j, alpha());
      prog_length(p, L);
    end
    prog_length(3, 20);
    prog_length(3, 2);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) < 5) clear = 1'b1;
      prog_sel = 2'($urandom_range(3));
      if ($urandom_range(99) < 10) begin
        prog_we = 1'b1; prog_addr = 4'($urandom_range(3)); prog_char = alpha();
      end
      if ($urandom_range(99) < 4) begin
        prog_len_we = 1'b1; prog_len = 5'($urandom_range(20));
      end
      if ($urandom_range(99) < 75) begin
        data_valid = 1'b1; data_in = {alpha(), alpha(), alpha(), alpha()};
      end
      tick();
    end
    idle(2);

    // asynchronous reset between edges mid-stream
    prog_str(0, "AB");
    send(32'h00000041);
    data_valid = 1'b1; data_in = 32'h42000000;
    @(negedge clk); #1;
    n_rst = 1'b0;
    #1;
    chk("t6_data", data_out, 32'd0);
    chk("t6_valid", 32'(data_out_valid), 32'd0);
    chk("t6_match", 32'(match), 32'd0);
    chk("t6_vec", 32'(match_vec), 32'd0);
    chk("t6_sticky", 32'(match_sticky), 32'd0);
    data_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    send(32'h41424142);
    chk("t6_after_vec", 32'(match_vec), 32'h0);
    send(32'h00000000);
    send(32'h42424242);
    idle(2);

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
